// File: rtl/vga_timing_pkg.sv
// Shared timing types, display presets and the timing-set validity check for vga_timing_gen.
package vga_timing_pkg;

  localparam int unsigned TIM_W = 16;

  typedef struct packed {
    logic [TIM_W-1:0] h_w;
    logic [TIM_W-1:0] h_fp;
    logic [TIM_W-1:0] h_pw;
    logic [TIM_W-1:0] h_bp;
    logic [TIM_W-1:0] v_h;
    logic [TIM_W-1:0] v_fp;
    logic [TIM_W-1:0] v_pw;
    logic [TIM_W-1:0] v_bp;
  } timing_t;

  localparam timing_t LCD_5INCH = '{
    h_w: TIM_W'(800), h_fp: TIM_W'(210), h_pw: TIM_W'(1), h_bp: TIM_W'(182),
    v_h: TIM_W'(480), v_fp: TIM_W'(62),  v_pw: TIM_W'(5), v_bp: TIM_W'(6)
  };

  localparam timing_t VGA_640_480 = '{
    h_w: TIM_W'(640), h_fp: TIM_W'(16), h_pw: TIM_W'(96), h_bp: TIM_W'(48),
    v_h: TIM_W'(480), v_fp: TIM_W'(10), v_pw: TIM_W'(2),  v_bp: TIM_W'(33)
  };

  // Active size and sync widths must be non-zero; porches may be empty.
  function automatic logic timing_valid(input timing_t t);
    return (t.h_w != '0) && (t.h_pw != '0) && (t.v_h != '0) && (t.v_pw != '0);
  endfunction

endpackage

// File: rtl/vga_sig_delay.sv
// Reset-to-idle shift register that aligns the sync/de vector; pass-through at depth 0.
module vga_sig_delay #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned W     = 3
) (
  input  logic         pix_clk,
  input  logic         pix_rst,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_shift
    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge pix_clk) begin
      if (pix_rst) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= rst_val;
      end else begin
        stage_q[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-reprogrammable raster timing generator with signed coordinates (active origin at 0,0).
// Define VGA_TIMING_FRAME_CNT_EN to add the 32-bit frame_cnt output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned COORD_W  = 16,
  parameter int unsigned CFG_W    = 12,
  parameter int unsigned DEF_H_W  = 640,
  parameter int unsigned DEF_H_FP = 16,
  parameter int unsigned DEF_H_PW = 96,
  parameter int unsigned DEF_H_BP = 48,
  parameter int unsigned DEF_V_H  = 480,
  parameter int unsigned DEF_V_FP = 10,
  parameter int unsigned DEF_V_PW = 2,
  parameter int unsigned DEF_V_BP = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned SYNC_DLY = 0
) (
  input  logic                      pix_clk,
  input  logic                      pix_rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CFG_W-1:0]          cfg_h_w,
  input  logic [CFG_W-1:0]          cfg_h_fp,
  input  logic [CFG_W-1:0]          cfg_h_pw,
  input  logic [CFG_W-1:0]          cfg_h_bp,
  input  logic [CFG_W-1:0]          cfg_v_h,
  input  logic [CFG_W-1:0]          cfg_v_fp,
  input  logic [CFG_W-1:0]          cfg_v_pw,
  input  logic [CFG_W-1:0]          cfg_v_bp,
  output logic                      cfg_err,
  output logic signed [COORD_W-1:0] sx,
  output logic signed [COORD_W-1:0] sy,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      de,
  output logic                      line_start,
  output logic                      frame_start,
  output logic                      frame_end
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [31:0]               frame_cnt
`endif
);

  function automatic logic signed [COORD_W-1:0] ext(input logic [TIM_W-1:0] v);
    return $signed(COORD_W'(v));
  endfunction

  // First blanking coordinate: -(front porch + pulse + back porch).
  function automatic logic signed [COORD_W-1:0] sta_of(input logic [TIM_W-1:0] fp,
                                                        input logic [TIM_W-1:0] pw,
                                                        input logic [TIM_W-1:0] bp);
    return -(ext(fp) + ext(pw) + ext(bp));
  endfunction

  localparam timing_t DEF_TIM = '{
    h_w: TIM_W'(DEF_H_W), h_fp: TIM_W'(DEF_H_FP), h_pw: TIM_W'(DEF_H_PW), h_bp: TIM_W'(DEF_H_BP),
    v_h: TIM_W'(DEF_V_H), v_fp: TIM_W'(DEF_V_FP), v_pw: TIM_W'(DEF_V_PW), v_bp: TIM_W'(DEF_V_BP)
  };
  localparam logic signed [COORD_W-1:0] ONE       = COORD_W'(1);
  localparam logic signed [COORD_W-1:0] DEF_H_STA = sta_of(DEF_TIM.h_fp, DEF_TIM.h_pw, DEF_TIM.h_bp);
  localparam logic signed [COORD_W-1:0] DEF_V_STA = sta_of(DEF_TIM.v_fp, DEF_TIM.v_pw, DEF_TIM.v_bp);
  localparam logic [2:0]                SYNC_IDLE = {1'b0, ~VS_POL, ~HS_POL};

  timing_t                   act_q, pend_q, cfg_in, nxt_tim;
  logic signed [COORD_W-1:0] pos_x_q, pos_y_q, pos_x_d, pos_y_d;
  logic signed [COORD_W-1:0] h_sta, v_sta, hs_lo, vs_lo;
  logic                      wrap_x, wrap_y, apply_c, pend_ok, xfer_c;
  logic                      hs_on, vs_on, de_on, frame_end_c;
  logic [2:0]                sync_c, sync_q, sync_dly;

  assign cfg_in = '{
    h_w: TIM_W'(cfg_h_w), h_fp: TIM_W'(cfg_h_fp), h_pw: TIM_W'(cfg_h_pw), h_bp: TIM_W'(cfg_h_bp),
    v_h: TIM_W'(cfg_v_h), v_fp: TIM_W'(cfg_v_fp), v_pw: TIM_W'(cfg_v_pw), v_bp: TIM_W'(cfg_v_bp)
  };
  assign xfer_c = cfg_valid && cfg_ready;

  // Scan advance, frame-boundary timing swap and sync/de decode from the current position.
  always_comb begin
    h_sta   = sta_of(act_q.h_fp, act_q.h_pw, act_q.h_bp);
    v_sta   = sta_of(act_q.v_fp, act_q.v_pw, act_q.v_bp);
    wrap_x  = (pos_x_q == ext(act_q.h_w) - ONE);
    wrap_y  = (pos_y_q == ext(act_q.v_h) - ONE);
    apply_c = wrap_x && wrap_y;
    pend_ok = timing_valid(pend_q);
    nxt_tim = act_q;
    if (apply_c && !cfg_ready && pend_ok) nxt_tim = pend_q;

    pos_x_d = pos_x_q + ONE;
    pos_y_d = pos_y_q;
    if (wrap_x) begin
      pos_x_d = sta_of(nxt_tim.h_fp, nxt_tim.h_pw, nxt_tim.h_bp);
      pos_y_d = wrap_y ? sta_of(nxt_tim.v_fp, nxt_tim.v_pw, nxt_tim.v_bp) : pos_y_q + ONE;
    end

    hs_lo       = h_sta + ext(act_q.h_fp);
    vs_lo       = v_sta + ext(act_q.v_fp);
    hs_on       = (pos_x_q >= hs_lo) && (pos_x_q < hs_lo + ext(act_q.h_pw));
    vs_on       = (pos_y_q >= vs_lo) && (pos_y_q < vs_lo + ext(act_q.v_pw));
    de_on       = !pos_x_q[COORD_W-1] && !pos_y_q[COORD_W-1];
    frame_end_c = (pos_x_q == h_sta) && (pos_y_q == v_sta);
    sync_c      = {de_on, vs_on ? VS_POL : ~VS_POL, hs_on ? HS_POL : ~HS_POL};
  end

  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      pos_x_q     <= DEF_H_STA;
      pos_y_q     <= DEF_V_STA;
      act_q       <= DEF_TIM;
      pend_q      <= '0;
      cfg_ready   <= 1'b1;
      cfg_err     <= 1'b0;
      sx          <= '0;
      sy          <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      sync_q      <= SYNC_IDLE;
    end else begin
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      act_q       <= nxt_tim;
      cfg_err     <= apply_c && !cfg_ready && !pend_ok;
      sx          <= pos_x_q;
      sy          <= pos_y_q;
      line_start  <= (pos_x_q == h_sta);
      frame_start <= (pos_x_q == '0) && (pos_y_q == '0);
      frame_end   <= frame_end_c;
      sync_q      <= sync_c;
      // A set accepted on the apply cycle itself waits for the next frame boundary.
      if (xfer_c) begin
        pend_q    <= cfg_in;
        cfg_ready <= 1'b0;
      end else if (apply_c && !cfg_ready) begin
        pend_q    <= '0;
        cfg_ready <= 1'b1;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge pix_clk) begin
    if (pix_rst)          frame_cnt <= '0;
    else if (frame_end_c) frame_cnt <= frame_cnt + 32'd1;
  end
`endif

  vga_sig_delay #(
    .DEPTH (SYNC_DLY),
    .W     (3)
  ) u_sync_dly (
    .pix_clk (pix_clk),
    .pix_rst (pix_rst),
    .rst_val (SYNC_IDLE),
    .d       (sync_q),
    .q       (sync_dly)
  );

  assign hsync = sync_dly[0];
  assign vsync = sync_dly[1];
  assign de    = sync_dly[2];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a frame-index reference model queues expected outputs, a monitor compares.
module tb_vga_timing_gen;

  localparam int unsigned COORD_W  = 16;
  localparam int unsigned CFG_W    = 12;
  localparam int unsigned SYNC_DLY = 2;
  localparam bit          HS_POL   = 1'b1;
  localparam bit          VS_POL   = 1'b0;

  typedef struct packed { int hw, hfp, hpw, hbp, vh, vfp, vpw, vbp; } tim_t;
  typedef struct packed {
    logic [15:0] sx, sy;
    logic        hs, vs, de, ls, fs, fe, rdy, err;
    logic [31:0] fcnt;
  } obs_t;

  localparam tim_t       DEF   = '{4, 1, 1, 2, 3, 1, 1, 1};
  localparam logic [2:0] IDLE3 = {1'b0, ~VS_POL, ~HS_POL};

  logic clk = 1'b0;
  logic pix_rst, cfg_valid, cfg_ready, cfg_err;
  logic [CFG_W-1:0] cfg_h_w, cfg_h_fp, cfg_h_pw, cfg_h_bp, cfg_v_h, cfg_v_fp, cfg_v_pw, cfg_v_bp;
  logic signed [COORD_W-1:0] sx, sy;
  logic hsync, vsync, de, line_start, frame_start, frame_end;
  logic [31:0] fcnt_w;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .COORD_W (COORD_W), .CFG_W (CFG_W),
    .DEF_H_W (4), .DEF_H_FP (1), .DEF_H_PW (1), .DEF_H_BP (2),
    .DEF_V_H (3), .DEF_V_FP (1), .DEF_V_PW (1), .DEF_V_BP (1),
    .HS_POL (HS_POL), .VS_POL (VS_POL), .SYNC_DLY (SYNC_DLY)
  ) dut (
    .pix_clk (clk), .pix_rst (pix_rst),
    .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
    .cfg_h_w (cfg_h_w), .cfg_h_fp (cfg_h_fp), .cfg_h_pw (cfg_h_pw), .cfg_h_bp (cfg_h_bp),
    .cfg_v_h (cfg_v_h), .cfg_v_fp (cfg_v_fp), .cfg_v_pw (cfg_v_pw), .cfg_v_bp (cfg_v_bp),
    .cfg_err (cfg_err), .sx (sx), .sy (sy),
    .hsync (hsync), .vsync (vsync), .de (de),
    .line_start (line_start), .frame_start (frame_start), .frame_end (frame_end)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt (fcnt_w)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign fcnt_w = 32'd0;
`endif

  // Reference model state: position is a cycle index within the current frame.
  tim_t        m_act, m_pend;
  bit          m_pend_vld, m_ready;
  int          m_t;
  logic [31:0] m_fcnt;
  logic [2:0]  hist[$];
  obs_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  function automatic bit tim_ok(input tim_t t);
    return t.hw >= 1 && t.hpw >= 1 && t.vh >= 1 && t.vpw >= 1;
  endfunction

  task automatic model_step(input bit rst, input bit v, input tim_t c);
    obs_t e;
    int hsta, vsta, lw, nl, x, y;
    bit apply;
    logic [2:0] s;
    e = '0;
    if (rst) begin
      m_act = DEF; m_t = 0; m_ready = 1; m_pend_vld = 0; m_fcnt = 0;
      hist.delete();
      for (int i = 0; i < int'(SYNC_DLY); i++) hist.push_back(IDLE3);
      e.hs = IDLE3[0]; e.vs = IDLE3[1]; e.rdy = 1'b1;
    end else begin
      hsta = -(m_act.hfp + m_act.hpw + m_act.hbp);
      vsta = -(m_act.vfp + m_act.vpw + m_act.vbp);
      lw   = m_act.hw - hsta;
      nl   = m_act.vh - vsta;
      x    = hsta + m_t % lw;
      y    = vsta + m_t / lw;
      apply = (m_t == lw * nl - 1);
      s[0] = (x >= hsta + m_act.hfp && x < hsta + m_act.hfp + m_act.hpw) ? HS_POL : ~HS_POL;
      s[1] = (y >= vsta + m_act.vfp && y < vsta + m_act.vfp + m_act.vpw) ? VS_POL : ~VS_POL;
      s[2] = (x >= 0 && y >= 0);
      hist.push_back(s);
      s = hist.pop_front();
      e.sx  = 16'(x);
      e.sy  = 16'(y);
      e.hs  = s[0]; e.vs = s[1]; e.de = s[2];
      e.ls  = (x == hsta);
      e.fs  = (x == 0 && y == 0);
      e.fe  = (x == hsta && y == vsta);
      e.err = apply && m_pend_vld && !tim_ok(m_pend);
      if (v && m_ready) begin
        m_pend = c; m_pend_vld = 1; m_ready = 0;
      end else if (apply && m_pend_vld) begin
        if (tim_ok(m_pend)) m_act = m_pend;
        m_pend_vld = 0; m_ready = 1;
      end
      m_t = apply ? 0 : m_t + 1;
      if (e.fe) m_fcnt = m_fcnt + 32'd1;
      e.rdy = m_ready;
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    e.fcnt = m_fcnt;
`endif
    exp_q.push_back(e);
  endtask

  task automatic step(input bit rst, input bit v, input tim_t c);
    @(negedge clk);
    pix_rst   = rst;
    cfg_valid = v;
    cfg_h_w = 12'(c.hw); cfg_h_fp = 12'(c.hfp); cfg_h_pw = 12'(c.hpw); cfg_h_bp = 12'(c.hbp);
    cfg_v_h = 12'(c.vh); cfg_v_fp = 12'(c.vfp); cfg_v_pw = 12'(c.vpw); cfg_v_bp = 12'(c.vbp);
    model_step(rst, v, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, DEF);
  endtask

  function automatic tim_t rand_tim();
    tim_t t;
    t.hw  = int'($urandom_range(1, 6));
    t.hfp = int'($urandom_range(0, 2));
    t.hpw = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 2));
    t.hbp = int'($urandom_range(0, 2));
    t.vh  = int'($urandom_range(1, 4));
    t.vfp = int'($urandom_range(0, 2));
    t.vpw = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 2));
    t.vbp = int'($urandom_range(0, 2));
    return t;
  endfunction

  // Monitor: every cycle the generator presents a full output set.
  obs_t mon_e, mon_a;
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {sx, sy, hsync, vsync, de, line_start, frame_start, frame_end, cfg_ready, cfg_err, fcnt_w};
      n_tests = n_tests + 1;
      if (mon_a !== mon_e) begin
        n_fail = n_fail + 1;
        $display("FAIL outputs cyc %0d: got sx=%0d sy=%0d hs/vs/de=%b%b%b ls/fs/fe=%b%b%b rdy=%b err=%b cnt=%0d; want sx=%0d sy=%0d hs/vs/de=%b%b%b ls/fs/fe=%b%b%b rdy=%b err=%b cnt=%0d",
                 cyc, $signed(mon_a.sx), $signed(mon_a.sy), mon_a.hs, mon_a.vs, mon_a.de,
                 mon_a.ls, mon_a.fs, mon_a.fe, mon_a.rdy, mon_a.err, mon_a.fcnt,
                 $signed(mon_e.sx), $signed(mon_e.sy), mon_e.hs, mon_e.vs, mon_e.de,
                 mon_e.ls, mon_e.fs, mon_e.fe, mon_e.rdy, mon_e.err, mon_e.fcnt);
      end
    end
  end

  initial begin
    pix_rst = 1'b1; cfg_valid = 1'b0;
    cfg_h_w = '0; cfg_h_fp = '0; cfg_h_pw = '0; cfg_h_bp = '0;
    cfg_v_h = '0; cfg_v_fp = '0; cfg_v_pw = '0; cfg_v_bp = '0;
    repeat (3) step(1'b1, 1'b0, DEF);
    idle(100);
    // Mid-frame reprogram to a 9-cycle line.
    idle(20);
    step(1'b0, 1'b1, '{6, 1, 1, 1, 3, 1, 1, 1});
    idle(150);
    // Invalid set (zero hsync width) is dropped at the frame wrap.
    step(1'b0, 1'b1, '{4, 1, 0, 2, 3, 1, 1, 1});
    idle(150);
    // Reset mid-frame with a set still pending.
    step(1'b0, 1'b1, '{5, 0, 1, 0, 2, 0, 1, 0});
    idle(13);
    step(1'b1, 1'b0, DEF);
    idle(120);
    // Randomized offers, field noise and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 399) == 0, $urandom_range(0, 29) == 0, rand_tim());
    end
    @(posedge clk);
    #2;
    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
